// File: rtl/lfsr_sched.sv
// Round-robin scheduler handing out values of a shared 8-bit LFSR, one fresh value per grant.
// Seed loading and a configurable warm-up run precede serving.
module lfsr_sched #(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       data,
    input  logic             seed_load,
    input  logic [7:0]       seed,
    output logic             ready
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW = PW + 1;
    localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);

    typedef enum logic {WARM, SERVE} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic [7:0]       s_reg, s_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [7:0]       data_reg, data_next;
    logic             ready_reg, ready_next;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[3] ^ s[1] ^ 1'b1};
    endfunction

    // Candidate gi is the requester gi positions after ptr, wrapped modulo N_REQ.
    logic [IW-1:0]    sum_w    [N_REQ];
    logic [PW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] req_rot;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign sum_w[gi]    = {1'b0, ptr_reg} + IW'(gi);
        assign cand_idx[gi] = (sum_w[gi] >= IW'(N_REQ)) ? PW'(sum_w[gi] - IW'(N_REQ))
                                                        : PW'(sum_w[gi]);
        assign req_rot[gi]  = req[cand_idx[gi]];
    end

    logic          found;
    logic [PW-1:0] sel;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        // Descending scan so the candidate nearest to ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found = 1'b1;
                sel   = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        s_next     = s_reg;
        ptr_next   = ptr_reg;
        gnt_next   = '0;
        data_next  = data_reg;
        ready_next = ready_reg;

        if (seed_load) begin
            // 8'hFF is the lock-up state of this feedback, so it is replaced by 8'h00.
            s_next     = (seed == 8'hFF) ? 8'h00 : seed;
            state_next = WARM;
            cnt_next   = 8'(WARMUP);
            ready_next = 1'b0;
        end else begin
            case (state_reg)
                WARM: begin
                    if (cnt_reg == 8'd0) begin
                        state_next = SERVE;
                        ready_next = 1'b1;
                    end else begin
                        s_next   = lfsr_step(s_reg);
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
                SERVE: begin
                    if (found) begin
                        gnt_next  = GNT_ONE << sel;
                        data_next = s_reg;
                        s_next    = lfsr_step(s_reg);
                        ptr_next  = (sel == PW'(N_REQ - 1)) ? '0 : sel + PW'(1);
                    end
                end
                default: state_next = WARM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WARM;
            cnt_reg   <= 8'(WARMUP);
            s_reg     <= 8'h00;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            data_reg  <= 8'h00;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            data_reg  <= data_next;
            ready_reg <= ready_next;
        end
    end

    assign gnt   = gnt_reg;
    assign data  = data_reg;
    assign ready = ready_reg;
endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: two instances (warm-up 4 and 0) share stimulus, checked against a
// cycle-level model every cycle plus directed literal expectations.
module tb_lfsr_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       seed_load;
    logic [7:0] seed;

    logic [3:0] gnt4, gnt0;
    logic [7:0] data4, data0;
    logic       ready4, ready0;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lfsr_sched #(.N_REQ(4), .WARMUP(4)) dut_w4 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt4), .data(data4),
        .seed_load(seed_load), .seed(seed), .ready(ready4)
    );

    lfsr_sched #(.N_REQ(4), .WARMUP(0)) dut_w0 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .data(data0),
        .seed_load(seed_load), .seed(seed), .ready(ready0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: unit 0 mirrors dut_w4, unit 1 mirrors dut_w0.
    function automatic logic [7:0] next_val(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[3] ^ s[1] ^ 1'b1};
    endfunction

    int         m_w     [2] = '{4, 0};
    bit         m_warm  [2] = '{1'b1, 1'b1};
    int         m_cnt   [2] = '{4, 0};
    logic [7:0] m_s     [2] = '{8'h00, 8'h00};
    int         m_ptr   [2] = '{0, 0};
    logic [3:0] m_gnt   [2] = '{4'h0, 4'h0};
    logic [7:0] m_data  [2] = '{8'h00, 8'h00};
    logic       m_ready [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_gnt[u] = 4'h0;
            if (rst) begin
                m_warm[u] = 1'b1; m_cnt[u] = m_w[u]; m_s[u] = 8'h00; m_ptr[u] = 0;
                m_data[u] = 8'h00; m_ready[u] = 1'b0;
            end else if (seed_load) begin
                m_s[u] = (seed == 8'hFF) ? 8'h00 : seed;
                m_warm[u] = 1'b1; m_cnt[u] = m_w[u]; m_ready[u] = 1'b0;
            end else if (m_warm[u]) begin
                if (m_cnt[u] == 0) begin
                    m_warm[u] = 1'b0; m_ready[u] = 1'b1;
                end else begin
                    m_s[u] = next_val(m_s[u]); m_cnt[u]--;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr[u] + k) % 4;
                    if (req[i]) begin
                        m_gnt[u] = 4'(1 << i);
                        m_data[u] = m_s[u];
                        m_s[u] = next_val(m_s[u]);
                        m_ptr[u] = (i + 1) % 4;
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gnt_w4", 32'(gnt4), 32'(m_gnt[0]));
            chk("model_data_w4", 32'(data4), 32'(m_data[0]));
            chk("model_ready_w4", 32'(ready4), 32'(m_ready[0]));
            chk("model_gnt_w0", 32'(gnt0), 32'(m_gnt[1]));
            chk("model_data_w0", 32'(data0), 32'(m_data[1]));
            chk("model_ready_w0", 32'(ready0), 32'(m_ready[1]));
            if (gnt4 != 4'h0) $display("t=%0t w4 grant gnt=%b data=%h", $time, gnt4, data4);
            if (gnt0 != 4'h0) $display("t=%0t w0 grant gnt=%b data=%h", $time, gnt0, data0);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] exp1_d [8]  = '{8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00, 8'h01};
    logic [7:0] exp2_d [10] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00, 8'h01};
    logic [3:0] exp2_g [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    logic [7:0] exp4_d [3]  = '{8'h30, 8'h60, 8'hC0};
    logic [3:0] exp4_g [3]  = '{4'b1000, 4'b0001, 4'b0010};
    logic [7:0] got2   [10];

    initial begin
        rst = 1'b1; req = 4'h0; seed_load = 1'b0; seed = 8'h00;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt4), 32'h0);
        chk("reset_data", 32'(data4), 32'h0);
        chk("reset_ready", 32'(ready4), 32'h0);

        // Warm-up of 4 steps, then a single requester held high.
        rst = 1'b0; req = 4'b0001;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 1) chk("w0_ready_after_1", 32'(ready0), 32'h1);
            if (e == 4) chk("w4_ready_low_at_4", 32'(ready4), 32'h0);
            if (e == 5) chk("w4_ready_at_5", 32'(ready4), 32'h1);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("single_gnt_%0d", k), 32'(gnt4), 32'h1);
            chk($sformatf("single_data_%0d", k), 32'(data4), 32'(exp1_d[k]));
        end

        // All requesters: strict rotation, ten distinct values.
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            got2[k] = data4;
            chk($sformatf("rr_gnt_%0d", k), 32'(gnt4), 32'(exp2_g[k]));
            chk($sformatf("rr_data_%0d", k), 32'(data4), 32'(exp2_d[k]));
        end
        begin
            int dups;
            dups = 0;
            for (int a = 0; a < 10; a++)
                for (int b = a + 1; b < 10; b++)
                    if (got2[a] == got2[b]) dups++;
            chk("rr_no_repeat", 32'(dups), 32'h0);
        end

        // Idle cycles must not consume values.
        req = 4'h0;
        repeat (20) tick();
        chk("idle_gnt", 32'(gnt4), 32'h0);
        req = 4'b0100;
        tick();
        chk("after_idle_gnt", 32'(gnt4), 32'b0100);
        chk("after_idle_data", 32'(data4), 32'h03);

        // Seed load into the zero-warm-up instance while it is serving.
        req = 4'b1111; seed_load = 1'b1; seed = 8'h30;
        tick();
        chk("seed_cycle_gnt_w0", 32'(gnt0), 32'h0);
        chk("seed_cycle_gnt_w4", 32'(gnt4), 32'h0);
        chk("seed_cycle_ready_w0", 32'(ready0), 32'h0);
        seed_load = 1'b0;
        tick();
        chk("seed_ready_w0", 32'(ready0), 32'h1);
        chk("seed_nogrant_w0", 32'(gnt0), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("seed_gnt_%0d", k), 32'(gnt0), 32'(exp4_g[k]));
            chk($sformatf("seed_data_%0d", k), 32'(data0), 32'(exp4_d[k]));
        end

        // Lock-up seed is substituted with 00.
        seed_load = 1'b1; seed = 8'hFF;
        tick();
        chk("ff_cycle_gnt", 32'(gnt0), 32'h0);
        seed_load = 1'b0;
        tick();
        chk("ff_ready", 32'(ready0), 32'h1);
        tick();
        chk("ff_data_0", 32'(data0), 32'h00);
        tick();
        chk("ff_data_1", 32'(data0), 32'h01);

        // Reset together with pending request and seed load.
        rst = 1'b1; seed_load = 1'b1; seed = 8'h55; req = 4'b1111;
        tick();
        chk("rst_mid_gnt_w4", 32'(gnt4), 32'h0);
        chk("rst_mid_data_w4", 32'(data4), 32'h0);
        chk("rst_mid_ready_w4", 32'(ready4), 32'h0);
        chk("rst_mid_gnt_w0", 32'(gnt0), 32'h0);
        chk("rst_mid_data_w0", 32'(data0), 32'h0);
        rst = 1'b0; seed_load = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("rst_warm_gnt_%0d", e), 32'(gnt4), 32'h0);
        end
        chk("rst_ready_w4", 32'(ready4), 32'h1);
        tick();
        chk("rst_first_gnt", 32'(gnt4), 32'h1);
        chk("rst_first_data", 32'(data4), 32'h0C);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Round-robin scheduler that shares one 8-bit pseudo-random generator between `N_REQ` requesters. It owns the generator state:
- feedback `fb = s[7]^s[5]^s[3]^s[1]^1`, next state `{s[6:0], fb}`, one step per advance.

It sequences seed loading and a warm-up run, then hands out one fresh value per grant. It sits between the random source and its consumers (test-pattern generators, dither, jitter units), so the draw order is deterministic and the same value is never given to two requesters.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `WARMUP`, 4, generator steps after reset/seed load before the first grant (0..255)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  `N_REQ`  request bits, level-sensitive, sampled every cycle
- `gnt`  out  `N_REQ`  one-hot grant, registered, one-cycle pulse
- `data`  out  8  random value; valid only in the cycle `gnt` is non-zero, otherwise held
- `seed_load`  in  1  load `seed` into the generator (one-cycle strobe)
- `seed`  in  8  seed value
- `ready`  out  1  high while in SERVE

## Operation
- State machine:
  - WARM: no grants; generator advances every cycle; counter decrements.
  - SERVE: arbitration active.
  - Transitions:
    - reset or `seed_load` -> WARM with counter=`WARMUP`
    - WARM and counter==0 -> SERVE (`WARMUP`=0: SERVE on the next cycle, zero warm steps)
- Seed substitution: a seed of 8'hFF is loaded as 8'h00. 8'hFF is the lock-up state (fb=1 keeps it at FF).
- Arbitration in SERVE:
  - Search `req` starting at index `ptr`, wrapping modulo `N_REQ`; grant the first set bit i.
  - On the edge: `gnt` <= one-hot(i), `data` <= current state `s`, `s` advances one step, `ptr` <= (i+1) mod `N_REQ`.
  - No request set: `gnt`=0, `s` and `ptr` unchanged.
- The generator advances only on grants (SERVE) or warm-up steps (WARM). Idle cycles do not consume values.
- A requester keeping `req` high after its grant stays eligible, but is only served again after the other asserted requesters: strict round-robin.
- `seed_load` has priority over everything:
  - in its cycle: no grant is issued, the pending request is not served, `ptr` is unchanged, state <= seed (after substitution), `ready` <= 0;
  - a second `seed_load` during WARM restarts the counter.
- Reset values: `s`=8'h00, `gnt`=0, `data`=8'h00, `ready`=0, `ptr`=0, state=WARM, counter=`WARMUP`.
- Reset mid-grant: the pending grant is dropped; `gnt` is 0 on the cycle after the reset edge.
- Width rules:
  - counter is 8 bits, `ptr` is $clog2(`N_REQ`) bits;
  - wrap arithmetic is explicit modulo `N_REQ`, including non-power-of-two values.

## Timing
- Request to grant: `req` sampled at edge k; `gnt`/`data` visible after edge k, for exactly one cycle.
- Throughput: one grant per cycle when any request is pending.
- `ready` rises on the same edge that enters SERVE. The first grant is possible on the edge after `ready` goes high.
- From reset release, with `WARMUP`=W: `ready` high after W+1 edges.
- Reference sequence from 8'h00: 00, 01, 03, 06, 0C, 18, 30, 60, C0, 80, 00. Period 10; the polynomial is not primitive, and this is accepted.

## Test plan
- Reset, `WARMUP`=4, then `req`=4'b0001 held -> `ready` after 5 edges. `gnt`=0001 every cycle with `data` = 0C, 18, 30, 60, C0, 80, 00, 01.
- All four `req` high continuously in SERVE -> `gnt` = 0001, 0010, 0100, 1000, 0001, …; `data` follows the reference sequence with no value repeated within 10 grants.
- `req`=0 for 20 cycles, then a single grant -> `data` equals the value the idle cycles would have left untouched (no advance while idle).
- `seed_load` with `seed`=8'h30 while `req`=1111 in SERVE, `WARMUP`=0:
  - load cycle: `gnt`=0;
  - next edge: `ready`=1;
  - following grants `data` = 30, 60, C0, continuing from the unchanged `ptr`.
- `seed_load` with `seed`=8'hFF, `WARMUP`=0 -> first grant `data`=00, second 01 (lock-up substitution).
- Assert `rst` in the same cycle as a pending `req` and a `seed_load` -> all outputs at reset values after the edge, and `gnt` stays 0 until `ready`.
